fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/rv32_pkg.sv | 22 ++
 rtl/if_id_reg.sv | 52 +++++
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 fetch-path definitions: NOP encoding, reset defaults,
// fetch FSM states and the fetch-address legality check.
package rv32_pkg;

    localparam logic [31:0] RV32_NOP           = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam int unsigned IMEM_WORDS_DEFAULT = 256;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    // Widened compare so that a word count near 2^30 cannot overflow the byte limit.
    function automatic logic addr_fault(input logic [31:0] addr, input int unsigned words);
        logic [33:0] limit;
        limit = {words, 2'b00};
        return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures a fetched instruction, holds, or flushes to NOP.
module if_id_reg
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        capture_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    // Flush wins over capture; the PC field is left as-is on flush since it is
    // only meaningful while valid.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush_i) begin
            valid_d = 1'b0;
            instr_d = RV32_NOP;
        end else if (capture_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0000_0000;
            instr_q <= RV32_NOP;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = valid_q ? instr_q : RV32_NOP;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, BOOT/RUN/FAULT control, delivered-instruction
// counter and the IF/ID register feeding decode.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_pc_o,
    input  logic [31:0] imem_instr_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o,
    output logic        fetch_fault_o,
    output logic [31:0] fetch_count_o
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  count_q, count_d;
    logic         fault_q, fault_d;
    logic         capture;
    logic         flush;

    // Redirect beats stall beats advance. A sequential step only proceeds when the
    // PC about to be fetched is legal, so running off the end of memory faults on
    // the edge after the last word is delivered, with the PC left where it was.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        fault_d = fault_q;
        capture = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect_valid_i) begin
                    flush = 1'b1;
                    if (addr_fault(redirect_pc_i, IMEM_WORDS)) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = redirect_pc_i;
                    end
                end else if (!stall_i) begin
                    if (addr_fault(pc_q, IMEM_WORDS)) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                        flush   = 1'b1;
                    end else begin
                        capture = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        count_d = count_q + 32'd1;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            count_q <= 32'h0000_0000;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            fault_q <= fault_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture_i (capture),
        .flush_i   (flush),
        .pc_i      (pc_q),
        .instr_i   (imem_instr_i),
        .valid_o   (ifid_valid_o),
        .pc_o      (ifid_pc_o),
        .instr_o   (ifid_instr_o)
    );

    assign imem_pc_o     = pc_q;
    assign fetch_fault_o = fault_q;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural fetch model compared every cycle,
// directed scenarios with literal expectations, and randomized stall/redirect bursts.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_pc_o;
    logic [31:0] imem_instr_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_instr_o;
    logic        fetch_fault_o;
    logic [31:0] fetch_count_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [256];

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (256)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_pc_o        (imem_pc_o),
        .imem_instr_i     (imem_instr_i),
        .ifid_valid_o     (ifid_valid_o),
        .ifid_pc_o        (ifid_pc_o),
        .ifid_instr_o     (ifid_instr_o),
        .fetch_fault_o    (fetch_fault_o),
        .fetch_count_o    (fetch_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_instr_i = mem[imem_pc_o[9:2]];

    // Reference model: what the fetch stage must be showing, tracked in plain terms.
    logic        mBooting = 1'b1;
    logic        mFault   = 1'b0;
    logic [31:0] mPc      = 32'h0;
    logic        mValid   = 1'b0;
    logic [31:0] mIfPc    = 32'h0;
    logic [31:0] mInstr   = NOP;
    logic [31:0] mCount   = 32'h0;

    function automatic bit illegalAddr(input logic [31:0] a);
        longint unsigned la;
        la = longint'(a);
        return ((la % 4) != 0) || (la >= 64'd1024);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBooting = 1'b1;
            mFault   = 1'b0;
            mPc      = 32'h0;
            mValid   = 1'b0;
            mIfPc    = 32'h0;
            mInstr   = NOP;
            mCount   = 32'h0;
        end else if (mFault) begin
            mFault = 1'b1;
        end else if (mBooting) begin
            mBooting = 1'b0;
        end else if (redirect_valid_i) begin
            mValid = 1'b0;
            mInstr = NOP;
            if (illegalAddr(redirect_pc_i)) mFault = 1'b1;
            else                            mPc    = redirect_pc_i;
        end else if (stall_i) begin
            mFault = 1'b0;
        end else if (illegalAddr(mPc)) begin
            mFault = 1'b1;
            mValid = 1'b0;
            mInstr = NOP;
        end else begin
            mIfPc  = mPc;
            mInstr = mem[mPc / 4];
            mValid = 1'b1;
            mPc    = mPc + 32'd4;
            mCount = mCount + 32'd1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at time %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("cmp_imem_pc", imem_pc_o, mPc);
        checkOutput("cmp_ifid_valid", {31'b0, ifid_valid_o}, {31'b0, mValid});
        checkOutput("cmp_ifid_pc", ifid_pc_o, mIfPc);
        checkOutput("cmp_ifid_instr", ifid_instr_o, mInstr);
        checkOutput("cmp_fault", {31'b0, fetch_fault_o}, {31'b0, mFault});
        checkOutput("cmp_count", fetch_count_o, mCount);
    end

    // Drives one cycle of inputs at a falling edge and returns at the next one.
    task automatic applyStimulus(input logic s, input logic rv, input logic [31:0] rpc);
        stall_i          = s;
        redirect_valid_i = rv;
        redirect_pc_i    = rpc;
        @(negedge clk);
    endtask

    task automatic resetPulse();
        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0;
        rst_n            = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] savedPc;
        logic [31:0] rpc;
        int unsigned w;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0;
        rst_n            = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("reset_valid", {31'b0, ifid_valid_o}, 32'd0);
        checkOutput("reset_instr", ifid_instr_o, NOP);
        checkOutput("reset_count", fetch_count_o, 32'd0);
        checkOutput("reset_imem_pc", imem_pc_o, 32'd0);
        checkOutput("reset_fault", {31'b0, fetch_fault_o}, 32'd0);
        rst_n = 1'b1;

        // Boot sequence and first deliveries
        applyStimulus(0, 0, 0);
        checkOutput("boot_no_valid", {31'b0, ifid_valid_o}, 32'd0);
        applyStimulus(0, 0, 0);
        checkOutput("first_ifid_pc", ifid_pc_o, 32'h0);
        checkOutput("first_instr", ifid_instr_o, 32'h1000_0000);
        checkOutput("first_valid", {31'b0, ifid_valid_o}, 32'd1);
        applyStimulus(0, 0, 0);
        checkOutput("second_ifid_pc", ifid_pc_o, 32'h4);
        checkOutput("second_count", fetch_count_o, 32'd2);
        checkOutput("second_imem_pc", imem_pc_o, 32'h8);

        // Three-cycle stall at PC=8
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0);
            checkOutput("stall_imem_pc", imem_pc_o, 32'h8);
            checkOutput("stall_ifid_pc", ifid_pc_o, 32'h4);
            checkOutput("stall_count", fetch_count_o, 32'd2);
        end
        applyStimulus(0, 0, 0);
        checkOutput("resume_ifid_pc", ifid_pc_o, 32'h8);
        checkOutput("resume_instr", ifid_instr_o, 32'h1000_0002);

        // Redirect together with stall
        applyStimulus(1, 1, 32'h40);
        checkOutput("redir_imem_pc", imem_pc_o, 32'h40);
        checkOutput("redir_valid", {31'b0, ifid_valid_o}, 32'd0);
        checkOutput("redir_instr", ifid_instr_o, NOP);
        applyStimulus(0, 0, 0);
        checkOutput("redir_ifid_pc", ifid_pc_o, 32'h40);
        checkOutput("redir_target_instr", ifid_instr_o, 32'h1000_0010);
        checkOutput("redir_count", fetch_count_o, 32'd4);

        // Misaligned redirect faults and sticks
        resetPulse();
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        savedPc = imem_pc_o;
        applyStimulus(0, 1, 32'h42);
        checkOutput("misalign_fault", {31'b0, fetch_fault_o}, 32'd1);
        checkOutput("misalign_imem_pc", imem_pc_o, 32'h4);
        checkOutput("misalign_valid", {31'b0, ifid_valid_o}, 32'd0);
        applyStimulus(0, 1, 32'h80);
        checkOutput("fault_ignores_redirect", imem_pc_o, savedPc);
        applyStimulus(0, 0, 0);
        checkOutput("fault_count_frozen", fetch_count_o, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("fault_reset_clears", {31'b0, fetch_fault_o}, 32'd0);
        checkOutput("fault_reset_pc", imem_pc_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Run off the end of instruction memory
        applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 32'h3F0);
        checkOutput("end_redir_pc", imem_pc_o, 32'h3F0);
        repeat (3) applyStimulus(0, 0, 0);
        checkOutput("end_ifid_3f8", ifid_pc_o, 32'h3F8);
        applyStimulus(0, 0, 0);
        checkOutput("end_last_pc", ifid_pc_o, 32'h3FC);
        checkOutput("end_last_instr", ifid_instr_o, 32'h1000_00FF);
        checkOutput("end_last_fault", {31'b0, fetch_fault_o}, 32'd0);
        applyStimulus(0, 0, 0);
        checkOutput("end_fault", {31'b0, fetch_fault_o}, 32'd1);
        checkOutput("end_no_valid", {31'b0, ifid_valid_o}, 32'd0);
        checkOutput("end_count", fetch_count_o, 32'd4);

        // Asynchronous reset mid-run
        resetPulse();
        repeat (6) applyStimulus(0, 0, 0);
        checkOutput("midrun_count", fetch_count_o, 32'd5);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_count", fetch_count_o, 32'd0);
        checkOutput("async_valid", {31'b0, ifid_valid_o}, 32'd0);
        checkOutput("async_imem_pc", imem_pc_o, 32'h0);
        checkOutput("async_instr", ifid_instr_o, NOP);
        checkOutput("async_ifid_pc", ifid_pc_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) applyStimulus(0, 0, 0);
        checkOutput("restart_pc", ifid_pc_o, 32'h0);
        checkOutput("restart_valid", {31'b0, ifid_valid_o}, 32'd1);

        // Randomized bursts, each starting from reset
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 256; i++) mem[i] = $urandom;
            resetPulse();
            for (int c = 0; c < 200; c++) begin
                w   = $urandom_range(0, 255);
                rpc = w * 4;
                if ($urandom_range(0, 39) == 0) rpc = rpc | 32'h1;
                else if ($urandom_range(0, 39) == 0) rpc = rpc + 32'h400;
                applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, rpc);
            end
        end

        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
